// File: rtl/conv1_udiv_20ns_19ns_20_seq.sv
// Sequential unsigned radix-2 restoring divider with start/done handshake and global ce stall.
// One quotient bit per ce edge; results registered and held until the next completion.
module conv1_udiv_20ns_19ns_20_seq #(
   parameter int          ID         = 1,
   parameter int unsigned din0_WIDTH = 20,
   parameter int unsigned din1_WIDTH = 19,
   parameter int unsigned dout_WIDTH = 20
) (
   input  logic                  ap_clk,
   input  logic                  ap_rst,
   input  logic                  ce,
   input  logic                  start,
   input  logic [din0_WIDTH-1:0] din0,
   input  logic [din1_WIDTH-1:0] din1,
   output logic                  busy,
   output logic                  done,
   output logic [dout_WIDTH-1:0] dout,
   output logic [din1_WIDTH-1:0] rem,
   output logic                  dbz,
   output logic                  ovf
);

   localparam int unsigned CW = $clog2(din0_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(din0_WIDTH - 1);

   typedef enum logic [0:0] {IDLE, CALC} state_t;

   state_t                state_q, state_d;
   logic [CW-1:0]         count_q, count_d;
   logic [din0_WIDTH-1:0] dq_q, dq_d;
   logic [din1_WIDTH-1:0] divisor_q, divisor_d;
   logic [din1_WIDTH-1:0] r_q, r_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;
   logic [dout_WIDTH-1:0] dout_q, dout_d;
   logic [din1_WIDTH-1:0] rem_q, rem_d;
   logic                  dbz_q, dbz_d;
   logic                  ovf_q, ovf_d;

   logic [din1_WIDTH:0]   trial;
   logic                  qbit;
   logic [din1_WIDTH-1:0] r_next;
   logic [din0_WIDTH-1:0] q_next;
   logic                  ovf_calc;
   logic                  unused_id;

   assign unused_id = (ID != 0);

   // dq_q shifts dividend bits out of the MSB while quotient bits fill the LSB;
   // after din0_WIDTH steps it holds the complete quotient.
   always_comb begin
      trial  = {r_q, dq_q[din0_WIDTH-1]};
      qbit   = (trial >= {1'b0, divisor_q});
      r_next = qbit ? (trial[din1_WIDTH-1:0] - divisor_q) : trial[din1_WIDTH-1:0];
      q_next = {dq_q[din0_WIDTH-2:0], qbit};
      ovf_calc = 1'b0;
      for (int unsigned i = dout_WIDTH; i < din0_WIDTH; i++) begin
         ovf_calc = ovf_calc | q_next[i];
      end
   end

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      dq_d      = dq_q;
      divisor_d = divisor_q;
      r_d       = r_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      dout_d    = dout_q;
      rem_d     = rem_q;
      dbz_d     = dbz_q;
      ovf_d     = ovf_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               dq_d      = din0;
               divisor_d = din1;
               r_d       = '0;
               count_d   = '0;
               busy_d    = 1'b1;
               state_d   = CALC;
            end
         end
         CALC: begin
            dq_d    = q_next;
            r_d     = r_next;
            count_d = count_q + 1'b1;
            if (count_q == LAST) begin
               dout_d  = q_next[dout_WIDTH-1:0];
               rem_d   = r_next;
               ovf_d   = ovf_calc;
               dbz_d   = (divisor_q == '0);
               done_d  = 1'b1;
               busy_d  = 1'b0;
               count_d = '0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge ap_clk or posedge ap_rst) begin
      if (ap_rst) begin
         state_q   <= IDLE;
         count_q   <= '0;
         dq_q      <= '0;
         divisor_q <= '0;
         r_q       <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         dout_q    <= '0;
         rem_q     <= '0;
         dbz_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else if (ce) begin
         state_q   <= state_d;
         count_q   <= count_d;
         dq_q      <= dq_d;
         divisor_q <= divisor_d;
         r_q       <= r_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         dout_q    <= dout_d;
         rem_q     <= rem_d;
         dbz_q     <= dbz_d;
         ovf_q     <= ovf_d;
      end
   end

   assign busy = busy_q;
   assign done = done_q;
   assign dout = dout_q;
   assign rem  = rem_q;
   assign dbz  = dbz_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_conv1_udiv_20ns_19ns_20_seq.sv
// Directed and randomised checks for the sequential unsigned divider, including a
// narrow-quotient instance that exercises the ovf flag.
module tb_conv1_udiv_20ns_19ns_20_seq;

   logic        ap_clk = 1'b0;
   logic        ap_rst;
   logic        ce;
   logic        start;
   logic [19:0] din0;
   logic [18:0] din1;
   logic        busy, done, dbz, ovf;
   logic [19:0] dout;
   logic [18:0] rem;
   logic        busy2, done2, dbz2, ovf2;
   logic [1:0]  dout2;
   logic [18:0] rem2;

   int checks = 0;
   int errors = 0;

   always #5 ap_clk = ~ap_clk;

   conv1_udiv_20ns_19ns_20_seq #(.ID(1), .din0_WIDTH(20), .din1_WIDTH(19), .dout_WIDTH(20)) dut (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .start(start), .din0(din0), .din1(din1),
      .busy(busy), .done(done), .dout(dout), .rem(rem), .dbz(dbz), .ovf(ovf));

   conv1_udiv_20ns_19ns_20_seq #(.ID(2), .din0_WIDTH(20), .din1_WIDTH(19), .dout_WIDTH(2)) dut_narrow (
      .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .start(start), .din0(din0), .din1(din1),
      .busy(busy2), .done(done2), .dout(dout2), .rem(rem2), .dbz(dbz2), .ovf(ovf2));

   // Issues one divide with ce held high; lat = edges from capture to done, -1 if no done.
   task automatic run_div(input logic [19:0] a, input logic [18:0] b, output int lat);
      din0 = a; din1 = b; start = 1'b1;
      @(posedge ap_clk); #1;
      start = 1'b0;
      lat = -1;
      for (int k = 1; k <= 100; k++) begin
         @(posedge ap_clk); #1;
         if (done) begin
            lat = k;
            break;
         end
      end
   endtask

   task automatic test_reset;
      ap_rst = 1'b1; ce = 1'b1; start = 1'b0; din0 = '0; din1 = '0;
      #1;
      checks++;
      if ({busy, done, dout, rem, dbz, ovf} !== '0) begin
         errors++; $display("FAIL reset_outputs got busy=%b done=%b dout=%h rem=%h dbz=%b ovf=%b want all 0",
                            busy, done, dout, rem, dbz, ovf);
      end
      repeat (2) @(posedge ap_clk);
      #1; ap_rst = 1'b0;
      @(posedge ap_clk); #1;
      checks++;
      if ({busy, done, dout} !== '0) begin
         errors++; $display("FAIL reset_idle got busy=%b done=%b dout=%h want 0", busy, done, dout);
      end
   endtask

   task automatic test_basic;
      int lat;
      int busy_bad;
      din0 = 20'd1000; din1 = 19'd7; start = 1'b1;
      @(posedge ap_clk); #1;
      start = 1'b0;
      lat = -1; busy_bad = 0;
      for (int k = 1; k <= 100; k++) begin
         @(posedge ap_clk); #1;
         if (done) begin lat = k; break; end
         if (busy !== 1'b1) busy_bad++;
      end
      checks++;
      if (lat != 20) begin errors++; $display("FAIL basic_latency got %0d want 20", lat); end
      checks++;
      if (busy_bad != 0 || busy !== 1'b0) begin
         errors++; $display("FAIL basic_busy got low_during=%0d busy_at_done=%b want 0/0", busy_bad, busy);
      end
      checks++;
      if (dout !== 20'd142 || rem !== 19'd6 || dbz !== 1'b0 || ovf !== 1'b0) begin
         errors++; $display("FAIL basic_1000_7 got q=%0d r=%0d dbz=%b ovf=%b want 142 6 0 0", dout, rem, dbz, ovf);
      end
      checks++;
      if (dout2 !== 2'd2 || ovf2 !== 1'b1) begin
         errors++; $display("FAIL narrow_1000_7 got q=%0d ovf=%b want 2 1", dout2, ovf2);
      end
      @(posedge ap_clk); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL done_pulse got %b want 0", done); end
   endtask

   task automatic test_boundary;
      int lat;
      run_div(20'd3, 19'd500000, lat);
      checks++;
      if (lat != 20 || dout !== 20'd0 || rem !== 19'd3) begin
         errors++; $display("FAIL small_dividend got lat=%0d q=%0d r=%0d want 20 0 3", lat, dout, rem);
      end
      run_div(20'hFFFFF, 19'd1, lat);
      checks++;
      if (dout !== 20'hFFFFF || rem !== 19'd0 || ovf !== 1'b0) begin
         errors++; $display("FAIL max_by_one got q=%h r=%0d ovf=%b want fffff 0 0", dout, rem, ovf);
      end
      checks++;
      if (dout2 !== 2'd3 || ovf2 !== 1'b1) begin
         errors++; $display("FAIL narrow_ovf got q=%0d ovf=%b want 3 1", dout2, ovf2);
      end
      run_div(20'd3, 19'd1, lat);
      checks++;
      if (dout2 !== 2'd3 || ovf2 !== 1'b0 || rem2 !== 19'd0) begin
         errors++; $display("FAIL narrow_no_ovf got q=%0d ovf=%b r=%0d want 3 0 0", dout2, ovf2, rem2);
      end
   endtask

   task automatic test_div_by_zero;
      int lat;
      run_div(20'd5, 19'd0, lat);
      checks++;
      if (lat != 20 || dout !== 20'hFFFFF || rem !== 19'd5 || dbz !== 1'b1) begin
         errors++; $display("FAIL dbz_5_0 got lat=%0d q=%h r=%0d dbz=%b want 20 fffff 5 1", lat, dout, rem, dbz);
      end
      run_div(20'd10, 19'd3, lat);
      checks++;
      if (dout !== 20'd3 || rem !== 19'd1 || dbz !== 1'b0) begin
         errors++; $display("FAIL after_dbz got q=%0d r=%0d dbz=%b want 3 1 0", dout, rem, dbz);
      end
   endtask

   task automatic test_back_to_back;
      int first_at, second_at;
      first_at = -1; second_at = -1;
      din0 = 20'd1000; din1 = 19'd7; start = 1'b1;
      @(posedge ap_clk); #1;
      for (int k = 1; k <= 60; k++) begin
         @(posedge ap_clk); #1;
         if (k == 10) begin din0 = 20'd5; din1 = 19'd1; end
         if (done && first_at < 0) begin
            first_at = k;
            checks++;
            if (dout !== 20'd142 || rem !== 19'd6) begin
               errors++; $display("FAIL b2b_first got q=%0d r=%0d want 142 6", dout, rem);
            end
            din0 = 20'd100; din1 = 19'd9;
         end else if (done) begin
            second_at = k;
            start = 1'b0;
            break;
         end
         if (k == 30) begin
            checks++;
            if (busy !== 1'b1 || dout !== 20'd142) begin
               errors++; $display("FAIL b2b_hold got busy=%b q=%0d want 1 142", busy, dout);
            end
         end
      end
      start = 1'b0;
      checks++;
      if (first_at != 20 || second_at != 41) begin
         errors++; $display("FAIL b2b_timing got done at %0d,%0d want 20,41", first_at, second_at);
      end
      checks++;
      if (dout !== 20'd11 || rem !== 19'd1) begin
         errors++; $display("FAIL b2b_second got q=%0d r=%0d want 11 1", dout, rem);
      end
      @(posedge ap_clk); #1;
   endtask

   task automatic test_ce_stall;
      int lat;
      din0 = 20'd1000; din1 = 19'd7; start = 1'b1;
      @(posedge ap_clk); #1;
      start = 1'b0;
      lat = 0;
      repeat (8) begin @(posedge ap_clk); #1; lat++; end
      ce = 1'b0;
      repeat (5) begin @(posedge ap_clk); #1; lat++; end
      checks++;
      if (busy !== 1'b1 || done !== 1'b0) begin
         errors++; $display("FAIL stall_frozen got busy=%b done=%b want 1 0", busy, done);
      end
      ce = 1'b1;
      for (int k = 0; k < 100; k++) begin
         @(posedge ap_clk); #1; lat++;
         if (done) break;
      end
      checks++;
      if (lat != 25 || dout !== 20'd142 || rem !== 19'd6) begin
         errors++; $display("FAIL stall_result got lat=%0d q=%0d r=%0d want 25 142 6", lat, dout, rem);
      end
      ce = 1'b0;
      repeat (3) @(posedge ap_clk);
      #1;
      checks++;
      if (done !== 1'b1 || dout !== 20'd142) begin
         errors++; $display("FAIL stall_done_hold got done=%b q=%0d want 1 142", done, dout);
      end
      ce = 1'b1;
      @(posedge ap_clk); #1;
      checks++;
      if (done !== 1'b0) begin errors++; $display("FAIL stall_done_drop got %b want 0", done); end
   endtask

   task automatic test_reset_mid;
      int seen;
      int lat;
      din0 = 20'd1000; din1 = 19'd7; start = 1'b1;
      @(posedge ap_clk); #1;
      start = 1'b0;
      repeat (10) @(posedge ap_clk);
      #3; ap_rst = 1'b1;
      #1;
      checks++;
      if ({busy, done, dout, rem, dbz, ovf} !== '0) begin
         errors++; $display("FAIL mid_reset got busy=%b dout=%0d rem=%0d want 0", busy, dout, rem);
      end
      #1; ap_rst = 1'b0;
      seen = 0;
      repeat (25) begin @(posedge ap_clk); #1; if (done || busy) seen++; end
      checks++;
      if (seen != 0) begin errors++; $display("FAIL mid_reset_abort got %0d active cycles want 0", seen); end
      run_div(20'd1000, 19'd7, lat);
      checks++;
      if (lat != 20 || dout !== 20'd142 || rem !== 19'd6) begin
         errors++; $display("FAIL post_reset got lat=%0d q=%0d r=%0d want 20 142 6", lat, dout, rem);
      end
   endtask

   task automatic test_random;
      logic [19:0] a, eq;
      logic [18:0] b, er;
      logic        got;
      for (int n = 0; n < 300; n++) begin
         case ($urandom_range(0, 5))
            0:       a = '0;
            1:       a = '1;
            default: a = 20'($urandom);
         endcase
         case ($urandom_range(0, 5))
            0:       b = '0;
            1:       b = '1;
            2:       b = 19'($urandom_range(1, 1000));
            default: b = 19'($urandom);
         endcase
         if (b == '0) begin
            eq = '1; er = a[18:0];
         end else begin
            eq = a / {1'b0, b}; er = 19'(a % {1'b0, b});
         end
         ce = 1'b1; din0 = a; din1 = b; start = 1'b1;
         @(posedge ap_clk); #1;
         start = 1'b0;
         got = 1'b0;
         for (int k = 0; k < 400; k++) begin
            ce = ($urandom_range(0, 3) != 0);
            @(posedge ap_clk); #1;
            if (done) begin got = 1'b1; break; end
         end
         ce = 1'b1;
         checks++;
         if (!got || dout !== eq || rem !== er || dbz !== (b == '0)) begin
            errors++; $display("FAIL random %h/%h got done=%b q=%h r=%h dbz=%b want %h %h %b",
                               a, b, got, dout, rem, dbz, eq, er, (b == '0));
         end
         checks++;
         if (dout2 !== eq[1:0] || ovf2 !== (|eq[19:2])) begin
            errors++; $display("FAIL random_narrow %h/%h got q=%0d ovf=%b want %0d %b",
                               a, b, dout2, ovf2, eq[1:0], |eq[19:2]);
         end
         @(posedge ap_clk); #1;
      end
   endtask

   initial begin
      #5_000_000;
      $display("FAIL global_timeout simulation did not finish");
      $fatal(1);
   end

   initial begin
      test_reset;
      test_basic;
      test_boundary;
      test_div_by_zero;
      test_back_to_back;
      test_ce_stall;
      test_reset_mid;
      test_random;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
